av_ram_arbiter: RTL

AV_RAM_ARBITER -- requirements
Module: av_ram_arbiter

---
 rtl/av_ram_arbiter_pkg.sv | 19 +
 rtl/spram_be.sv | 37 +++
 rtl/av_ram_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/av_ram_arbiter_pkg.sv
// Shared types and constants for the two-port Avalon RAM arbiter.
// Port indices, default address-select width and the register-address width helper.
package av_ram_arbiter_pkg;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam int unsigned AV_ADDR_SPAN          = 30;
    localparam int unsigned ADDR_SEL_BITS_DEFAULT = 6;
    localparam int unsigned NUM_BYTES             = 4;

    // Word-address width seen by a slave once the upstream decode bits are stripped.
    function automatic int unsigned reg_addr_w(input int unsigned addr_sel_bits);
        return AV_ADDR_SPAN - addr_sel_bits;
    endfunction

endpackage

// File: rtl/spram_be.sv
// Single-port 32-bit RAM with per-byte write enables and a 1-cycle registered read.
// Contents start at zero from configuration and are never reset.
module spram_be
    import av_ram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [NUM_BYTES-1:0] be_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem [DEPTH] = '{default: '0};
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                    if (be_i[k]) begin
                        mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/av_ram_arbiter.sv
// Two Avalon-MM slave ports sharing one single-port RAM through a round-robin arbiter.
// One grant per cycle; the loser sees WaitRequest and retries the next cycle.
module av_ram_arbiter
    import av_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_SEL_BITS = ADDR_SEL_BITS_DEFAULT,
    parameter int unsigned DEPTH         = 1024
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Rst_n,

    input  logic                                   i_AV0_SlaveSel,
    input  logic [reg_addr_w(ADDR_SEL_BITS)-1:0]   i_AV0_RegAddr,
    input  logic                                   i_AV0_Read,
    input  logic                                   i_AV0_Write,
    input  logic [31:0]                            i_AV0_WriteData,
    input  logic [NUM_BYTES-1:0]                   i_AV0_ByteEnable,
    output logic [31:0]                            o_AV0_ReadData,
    output logic                                   o_AV0_WaitRequest,

    input  logic                                   i_AV1_SlaveSel,
    input  logic [reg_addr_w(ADDR_SEL_BITS)-1:0]   i_AV1_RegAddr,
    input  logic                                   i_AV1_Read,
    input  logic                                   i_AV1_Write,
    input  logic [31:0]                            i_AV1_WriteData,
    input  logic [NUM_BYTES-1:0]                   i_AV1_ByteEnable,
    output logic [31:0]                            o_AV1_ReadData,
    output logic                                   o_AV1_WaitRequest
);

    localparam int unsigned REG_AW = reg_addr_w(ADDR_SEL_BITS);
    localparam int unsigned AW     = $clog2(DEPTH);

    logic                 req0, req1;
    logic                 grant0, grant1;
    port_e                last_grant_q, last_grant_d;
    logic [1:0]           rd_valid_q, rd_valid_d;

    logic                 ram_en, ram_we;
    logic [AW-1:0]        ram_addr;
    logic [31:0]          ram_wdata, ram_rdata;
    logic [NUM_BYTES-1:0] ram_be;

    // Upper address bits belong to a larger window; they alias onto the RAM.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^{i_AV0_RegAddr[REG_AW-1:AW], i_AV1_RegAddr[REG_AW-1:AW]};

    assign req0 = i_AV0_SlaveSel & (i_AV0_Read | i_AV0_Write);
    assign req1 = i_AV1_SlaveSel & (i_AV1_Read | i_AV1_Write);

    // Grant is gated by reset so nothing is accepted, and no RAM write fires, while held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_Rst_n) begin
            if (req0 && (!req1 || last_grant_q == PORT1)) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = PORT0;
        end else if (grant1) begin
            last_grant_d = PORT1;
        end
        // Read+Write together is a write, so it never produces read data.
        rd_valid_d[0] = grant0 & i_AV0_Read & ~i_AV0_Write;
        rd_valid_d[1] = grant1 & i_AV1_Read & ~i_AV1_Write;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            last_grant_q <= PORT1;
            rd_valid_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_comb begin
        ram_en    = grant0 | grant1;
        ram_we    = grant1 ? i_AV1_Write      : i_AV0_Write;
        ram_addr  = grant1 ? i_AV1_RegAddr[AW-1:0] : i_AV0_RegAddr[AW-1:0];
        ram_wdata = grant1 ? i_AV1_WriteData  : i_AV0_WriteData;
        ram_be    = grant1 ? i_AV1_ByteEnable : i_AV0_ByteEnable;
    end

    spram_be #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (i_Clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .be_i    (ram_be),
        .rdata_o (ram_rdata)
    );

    // The shared RAM output is only shown to the port whose read was granted last cycle.
    assign o_AV0_ReadData    = rd_valid_q[0] ? ram_rdata : '0;
    assign o_AV1_ReadData    = rd_valid_q[1] ? ram_rdata : '0;
    assign o_AV0_WaitRequest = req0 & ~grant0;
    assign o_AV1_WaitRequest = req1 & ~grant1;

endmodule
